pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle control FSM for the RISC CPU. It sequences instruction fetch, decode, execute and memory access, and it is the only block that drives the program counter's load enable (`Cen`) and next-value input (`PCIn`). It sits between the instruction register / ALU flags and the PC, register file and memory ports. It resolves sequential, jump, conditional-branch and (optionally) call/return flow.

## Interface
Parameters:
- `PC_W`, default 8: program counter width.
- `STACK_DEPTH`, default 4: return-address stack entries. Used only with `PC_SEQ_CALL_EN`.

Ports:
- `Clk` input, 1 bit: clock. All state changes on the rising edge.
- `Rst` input, 1 bit: reset, asynchronous, active-high.
- `PCOut` input, `PC_W` bits: current PC value, fed back from the program counter.
- `Opcode` input, 4 bits: opcode field of the instruction register. Valid from DECODE onward.
- `Target` input, `PC_W` bits: jump, branch or call target from the instruction register.
- `Zero` input, 1 bit: ALU zero flag, sampled in EXEC.
- `MemReady` input, 1 bit: memory handshake completion, shared by instruction and data accesses.
- `PCIn` output, `PC_W` bits: next PC value. Only meaningful while `Cen`=1.
- `Cen` output, 1 bit: PC load enable, a one-cycle pulse per instruction.
- `IRLoad` output, 1 bit: instruction register load pulse.
- `MemRd` output, 1 bit: memory read request.
- `MemWe` output, 1 bit: memory write request.
- `RegWe` output, 1 bit: register file write pulse.
- `Halted` output, 1 bit: the core is stopped.
- `Fault` output, 1 bit: an illegal opcode or stack error occurred. Sticky.

## Operation
- Opcodes:
  - NOP=0x0, ALU=0x1, LOAD=0x2, STORE=0x3, JMP=0x4, BZ=0x5, BNZ=0x6, CALL=0x7, RET=0x8, HALT=0xF.
  - 0x9–0xE are illegal.
- FSM states: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH:
  - Hold `MemRd`=1 (address is `PCOut`) until `MemReady`=1.
  - In the cycle where `MemReady`=1, assert `IRLoad`=1, then go to DECODE.
- DECODE: one cycle, no outputs asserted. Go to EXEC.
- EXEC: one cycle, behaviour depends on opcode.
  - NOP: `Cen`=1, `PCIn`=`PCOut`+1.
  - ALU: `RegWe`=1, `Cen`=1, `PCIn`=`PCOut`+1.
  - LOAD/STORE: no outputs; go to MEM.
  - JMP: `Cen`=1, `PCIn`=`Target`.
  - BZ: `Cen`=1, `PCIn` = `Zero` ? `Target` : `PCOut`+1.
  - BNZ: the inverse of BZ.
  - CALL/RET: see Configuration.
  - HALT or an illegal opcode: `Cen`=0, go to HALT. An illegal opcode also sets `Fault`.
  - All other opcodes return to FETCH.
- MEM:
  - Hold `MemRd` (LOAD) or `MemWe` (STORE) until `MemReady`=1.
  - In that cycle: `Cen`=1, `PCIn`=`PCOut`+1, and `RegWe`=1 for LOAD. Then go to FETCH.
- HALT: absorbing state. All pulses stay 0 and `Halted`=1. Only `Rst` leaves it.
- Arithmetic: `PCOut`+1 is modulo 2^`PC_W`, so 0xFF wraps to 0x00 at `PC_W`=8. There is no carry out.
- `Cen` is asserted exactly once per retired instruction. It is never asserted in FETCH or DECODE.

## Timing
- Reset:
  - State goes to FETCH.
  - All outputs are 0, including `PCIn`=0, `Halted`=0 and `Fault`=0.
  - The stack pointer is 0.
- Reset mid-operation: any pending memory request is dropped in the same cycle. No `Cen`, `RegWe` or `MemWe` pulse completes.
- `MemRd` is asserted one cycle after reset deasserts, in the first FETCH cycle.
- Outputs are registered and asserted during the cycle the FSM occupies the owning state.
- The PC captures `PCIn` on the edge that ends EXEC or MEM. The next FETCH therefore sees the new `PCOut`.
- Minimum latency with `MemReady` held at 1:
  - NOP, ALU, JMP, branch, CALL, RET: 3 cycles (FETCH, DECODE, EXEC).
  - LOAD, STORE: 4 cycles (adds MEM).
- Each cycle with `MemReady`=0 adds one cycle. There is no timeout.
- `MemReady` is ignored outside FETCH and MEM.

## Configuration
- `PC_SEQ_CALL_EN` defined:
  - A return stack of `STACK_DEPTH` entries, each `PC_W` bits wide, is instantiated.
  - CALL pushes `PCOut`+1 and loads `Target`.
  - RET pops into `PCIn`. Both assert `Cen` in EXEC.
  - Push when full, or pop when empty: no `Cen`, the stack is unchanged, `Fault`=1, go to HALT.
  - A CALL at `PCOut`=0xFF pushes 0x00.
- `PC_SEQ_CALL_EN` undefined: CALL and RET are illegal opcodes (`Fault`, then HALT). No stack storage is built.

## Structure
- The shared package `pc_seq_pkg` holds:
  - the opcode constants;
  - the state encoding typedef;
  - the `PC_W` default.
- The optional sub-module is `pc_ret_stack`: a LIFO with push, pop, full and empty signals and an asynchronous reset. It is instantiated only under `PC_SEQ_CALL_EN`.

## Test plan
- Reset, then `MemReady`=1 and `Opcode`=NOP repeated from `PCOut`=0x00: `Cen` pulses every 3rd cycle with `PCIn`=0x01, 0x02, 0x03. At `PCOut`=0xFF, `PCIn`=0x00.
- LOAD with `MemReady` low for 2 MEM cycles: `MemRd` is high 3 cycles in MEM. `RegWe` and `Cen` pulse together in the third cycle, with `PCIn`=`PCOut`+1.
- BZ with `Target`=0x40 at `PCOut`=0x10: `Zero`=1 gives `PCIn`=0x40, `Zero`=0 gives 0x11. BNZ gives the opposite results.
- HALT and an illegal opcode 0xA: no further `Cen`, `Halted`=1. `Fault`=1 only for 0xA. Asserting `Rst` returns to FETCH with all outputs 0.
- With `PC_SEQ_CALL_EN`:
  - CALL 0x20 at 0x05 loads 0x20; a following RET gives `PCIn`=0x06.
  - 5 nested CALLs at depth 4 give `Fault`=1 and `Halted`=1, with no fifth push.
- `Rst` asserted mid-FETCH while `MemRd`=1: `MemRd` drops without waiting for a clock edge, and `IRLoad` is never asserted.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: opcode map, FSM state encoding, default PC width.
// Call/return support in the sequencer is enabled by defining PC_SEQ_CALL_EN.
package pc_seq_pkg;

    localparam int PC_W_DEF = 8;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_BZ    = 4'h5;
    localparam logic [3:0] OP_BNZ   = 4'h6;
    localparam logic [3:0] OP_CALL  = 4'h7;
    localparam logic [3:0] OP_RET   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for CALL/RET; built only when PC_SEQ_CALL_EN is defined.
// Push when full and pop when empty are ignored; the sequencer faults on those cases.
`ifdef PC_SEQ_CALL_EN
module pc_ret_stack #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] top_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0] sp_q;
    logic [PC_W-1:0] mem_q [DEPTH];

    assign full_o  = (sp_q == SP_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    // Index wraps when empty; callers only look at top_o when not empty.
    assign top_o   = mem_q[IDX_W'(sp_q - SP_W'(1))];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[IDX_W'(sp_q)] <= data_i;
        end
    end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/memory control FSM; sole driver of the PC load (Cen/PCIn).
// Define PC_SEQ_CALL_EN to build the return stack and enable CALL/RET; otherwise they fault.
import pc_seq_pkg::*;

module pc_sequencer #(
    parameter int PC_W        = PC_W_DEF,
    parameter int STACK_DEPTH = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [PC_W-1:0] PCOut,
    input  logic [3:0]      Opcode,
    input  logic [PC_W-1:0] Target,
    input  logic            Zero,
    input  logic            MemReady,
    output logic [PC_W-1:0] PCIn,
    output logic            Cen,
    output logic            IRLoad,
    output logic            MemRd,
    output logic            MemWe,
    output logic            RegWe,
    output logic            Halted,
    output logic            Fault
);

    state_t          state_q;
    logic [PC_W-1:0] pcin_q;
    logic            cen_q, regwe_q, memrd_q, memwe_q, load_q;
    logic            mem_go_q, halt_go_q, fault_go_q;
    logic            halted_q, fault_q;
    logic [PC_W-1:0] pc_inc;
    logic            mem_done;

    assign pc_inc = PCOut + PC_W'(1);

`ifdef PC_SEQ_CALL_EN
    logic            stk_push, stk_pop, stk_full, stk_empty;
    logic [PC_W-1:0] stk_top;

    // Stack moves on the DECODE->EXEC edge, together with the registered EXEC outputs.
    assign stk_push = (state_q == S_DECODE) && (Opcode == OP_CALL) && !stk_full;
    assign stk_pop  = (state_q == S_DECODE) && (Opcode == OP_RET) && !stk_empty;

    pc_ret_stack #(
        .PC_W  (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .data_i  (pc_inc),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );
`else
    logic unused_depth;
    assign unused_depth = |STACK_DEPTH;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_FETCH;
            pcin_q     <= '0;
            cen_q      <= 1'b0;
            regwe_q    <= 1'b0;
            memrd_q    <= 1'b0;
            memwe_q    <= 1'b0;
            load_q     <= 1'b0;
            mem_go_q   <= 1'b0;
            halt_go_q  <= 1'b0;
            fault_go_q <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            cen_q   <= 1'b0;
            regwe_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    // First FETCH after reset spends one cycle raising MemRd.
                    if (!memrd_q) begin
                        memrd_q <= 1'b1;
                    end else if (MemReady) begin
                        memrd_q <= 1'b0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXEC;
                    case (Opcode)
                        OP_NOP: begin
                            cen_q  <= 1'b1;
                            pcin_q <= pc_inc;
                        end
                        OP_ALU: begin
                            cen_q   <= 1'b1;
                            regwe_q <= 1'b1;
                            pcin_q  <= pc_inc;
                        end
                        OP_LOAD: begin
                            mem_go_q <= 1'b1;
                            load_q   <= 1'b1;
                        end
                        OP_STORE: begin
                            mem_go_q <= 1'b1;
                            load_q   <= 1'b0;
                        end
                        OP_JMP: begin
                            cen_q  <= 1'b1;
                            pcin_q <= Target;
                        end
                        OP_BZ: begin
                            cen_q  <= 1'b1;
                            pcin_q <= Zero ? Target : pc_inc;
                        end
                        OP_BNZ: begin
                            cen_q  <= 1'b1;
                            pcin_q <= Zero ? pc_inc : Target;
                        end
`ifdef PC_SEQ_CALL_EN
                        OP_CALL: begin
                            if (!stk_full) begin
                                cen_q  <= 1'b1;
                                pcin_q <= Target;
                            end else begin
                                halt_go_q  <= 1'b1;
                                fault_go_q <= 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (!stk_empty) begin
                                cen_q  <= 1'b1;
                                pcin_q <= stk_top;
                            end else begin
                                halt_go_q  <= 1'b1;
                                fault_go_q <= 1'b1;
                            end
                        end
`endif
                        OP_HALT: halt_go_q <= 1'b1;
                        default: begin
                            halt_go_q  <= 1'b1;
                            fault_go_q <= 1'b1;
                        end
                    endcase
                end
                S_EXEC: begin
                    mem_go_q   <= 1'b0;
                    halt_go_q  <= 1'b0;
                    fault_go_q <= 1'b0;
                    if (mem_go_q) begin
                        state_q <= S_MEM;
                        memrd_q <= load_q;
                        memwe_q <= ~load_q;
                        pcin_q  <= pc_inc;
                    end else if (halt_go_q) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        fault_q  <= fault_q | fault_go_q;
                    end else begin
                        state_q <= S_FETCH;
                        memrd_q <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (MemReady) begin
                        state_q <= S_FETCH;
                        memrd_q <= 1'b1;
                        memwe_q <= 1'b0;
                    end
                end
                S_HALT: begin
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Handshake completions qualify the registered state with MemReady so they land
    // in the ready cycle itself; an async reset of state_q kills them immediately.
    assign mem_done = (state_q == S_MEM) && MemReady;
    assign IRLoad   = (state_q == S_FETCH) && memrd_q && MemReady;
    assign Cen      = cen_q | mem_done;
    assign RegWe    = regwe_q | (mem_done & load_q);
    assign PCIn     = pcin_q;
    assign MemRd    = memrd_q;
    assign MemWe    = memwe_q;
    assign Halted   = halted_q;
    assign Fault    = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change on the falling edge, outputs checked 1 ns later.
// Covers the CALL/RET behaviour of whichever build (PC_SEQ_CALL_EN defined or not) is compiled.
module tb_pc_sequencer;

    localparam logic [6:0] F_CEN = 7'b1000000;
    localparam logic [6:0] F_IRL = 7'b0100000;
    localparam logic [6:0] F_RD  = 7'b0010000;
    localparam logic [6:0] F_WE  = 7'b0001000;
    localparam logic [6:0] F_RWE = 7'b0000100;
    localparam logic [6:0] F_HLT = 7'b0000010;
    localparam logic [6:0] F_FLT = 7'b0000001;

    logic       Clk, Rst;
    logic [7:0] PCOut, Target, PCIn;
    logic [3:0] Opcode;
    logic       Zero, MemReady;
    logic       Cen, IRLoad, MemRd, MemWe, RegWe, Halted, Fault;
    logic [6:0] flags;

    int errors = 0;
    int checks = 0;

    assign flags = {Cen, IRLoad, MemRd, MemWe, RegWe, Halted, Fault};

    pc_sequencer dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .PCOut    (PCOut),
        .Opcode   (Opcode),
        .Target   (Target),
        .Zero     (Zero),
        .MemReady (MemReady),
        .PCIn     (PCIn),
        .Cen      (Cen),
        .IRLoad   (IRLoad),
        .MemRd    (MemRd),
        .MemWe    (MemWe),
        .RegWe    (RegWe),
        .Halted   (Halted),
        .Fault    (Fault)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold reset across one rising edge, verify everything is cleared, then release.
    task automatic do_reset(input string tag);
        @(negedge Clk);
        Rst = 1'b1;
        MemReady = 1'b1;
        #1;
        chk({tag, "/flags"}, 32'(flags), 32'h0);
        chk({tag, "/pcin"}, 32'(PCIn), 32'h0);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    // One FETCH/DECODE/EXEC pass with MemReady high; EXEC flags and PCIn checked.
    task automatic instr3(input string tag, input logic [7:0] pc, input logic [3:0] op,
                          input logic [6:0] exp_ex, input logic [7:0] exp_pc);
        @(negedge Clk);
        PCOut = pc;
        Opcode = op;
        MemReady = 1'b1;
        #1;
        chk({tag, "/fetch"}, 32'(flags), 32'(F_RD | F_IRL));
        @(negedge Clk);
        #1;
        chk({tag, "/decode"}, 32'(flags), 32'h0);
        @(negedge Clk);
        #1;
        chk({tag, "/exec"}, 32'(flags), 32'(exp_ex));
        if (exp_ex[6]) chk({tag, "/pcin"}, 32'(PCIn), 32'(exp_pc));
    endtask

    task automatic chk_halt(input string tag, input logic [6:0] exp);
        @(negedge Clk);
        #1;
        chk(tag, 32'(flags), 32'(exp));
    endtask

    initial begin
        Rst = 1'b1;
        MemReady = 1'b0;
        Opcode = 4'h0;
        PCOut = 8'h00;
        Target = 8'h00;
        Zero = 1'b0;
        do_reset("reset");

        // Sequential NOPs and the PC wrap
        instr3("nop0", 8'h00, 4'h0, F_CEN, 8'h01);
        instr3("nop1", 8'h01, 4'h0, F_CEN, 8'h02);
        instr3("nop2", 8'h02, 4'h0, F_CEN, 8'h03);
        instr3("nopwrap", 8'hFF, 4'h0, F_CEN, 8'h00);
        instr3("alu", 8'h03, 4'h1, F_CEN | F_RWE, 8'h04);
        Target = 8'h80;
        instr3("jmp", 8'h04, 4'h4, F_CEN, 8'h80);

        // Branches
        Target = 8'h40;
        Zero = 1'b1;
        instr3("bz_taken", 8'h10, 4'h5, F_CEN, 8'h40);
        Zero = 1'b0;
        instr3("bz_fall", 8'h10, 4'h5, F_CEN, 8'h11);
        Zero = 1'b1;
        instr3("bnz_fall", 8'h10, 4'h6, F_CEN, 8'h11);
        Zero = 1'b0;
        instr3("bnz_taken", 8'h10, 4'h6, F_CEN, 8'h40);

        // Instruction fetch stalled for one cycle
        @(negedge Clk);
        PCOut = 8'h50;
        Opcode = 4'h0;
        MemReady = 1'b0;
        #1;
        chk("fetch_stall", 32'(flags), 32'(F_RD));
        instr3("after_stall", 8'h50, 4'h0, F_CEN, 8'h51);

        // LOAD with two wait cycles in MEM
        instr3("load", 8'h20, 4'h2, 7'h0, 8'h00);
        @(negedge Clk);
        MemReady = 1'b0;
        #1;
        chk("load/mem1", 32'(flags), 32'(F_RD));
        @(negedge Clk);
        #1;
        chk("load/mem2", 32'(flags), 32'(F_RD));
        @(negedge Clk);
        MemReady = 1'b1;
        #1;
        chk("load/mem3", 32'(flags), 32'(F_RD | F_CEN | F_RWE));
        chk("load/pcin", 32'(PCIn), 32'h21);

        // STORE with immediate ready
        instr3("store", 8'h30, 4'h3, 7'h0, 8'h00);
        @(negedge Clk);
        #1;
        chk("store/mem", 32'(flags), 32'(F_WE | F_CEN));
        chk("store/pcin", 32'(PCIn), 32'h31);

        // Reset in the middle of an outstanding fetch
        @(negedge Clk);
        PCOut = 8'h60;
        MemReady = 1'b0;
        #1;
        chk("midrst/fetch", 32'(flags), 32'(F_RD));
        #1;
        Rst = 1'b1;
        MemReady = 1'b1;
        #1;
        chk("midrst/async", 32'(flags), 32'h0);
        @(negedge Clk);
        #1;
        chk("midrst/held", 32'(flags), 32'h0);
        @(negedge Clk);
        Rst = 1'b0;
        instr3("midrst/next", 8'h60, 4'h0, F_CEN, 8'h61);

        // HALT: absorbing, no fault
        instr3("halt", 8'h07, 4'hF, 7'h0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            MemReady = i[0];
            #1;
            chk("halt/hold", 32'(flags), 32'(F_HLT));
        end
        do_reset("halt_rst");

        // Illegal opcode 0xA
        instr3("illegal", 8'h08, 4'hA, 7'h0, 8'h00);
        chk_halt("illegal/halt1", F_HLT | F_FLT);
        chk_halt("illegal/halt2", F_HLT | F_FLT);
        do_reset("ill_rst");

`ifdef PC_SEQ_CALL_EN
        Target = 8'h20;
        instr3("call", 8'h05, 4'h7, F_CEN, 8'h20);
        instr3("ret", 8'h20, 4'h8, F_CEN, 8'h06);
        Target = 8'h33;
        instr3("call_ff", 8'hFF, 4'h7, F_CEN, 8'h33);
        instr3("ret_wrap", 8'h33, 4'h8, F_CEN, 8'h00);
        instr3("ret_empty", 8'h00, 4'h8, 7'h0, 8'h00);
        chk_halt("ret_empty/halt", F_HLT | F_FLT);
        do_reset("ret_rst");
        for (int i = 0; i < 4; i++) begin
            instr3("nest", 8'(i), 4'h7, F_CEN, 8'h33);
        end
        instr3("nest5", 8'h04, 4'h7, 7'h0, 8'h00);
        chk_halt("nest5/halt", F_HLT | F_FLT);
        do_reset("nest_rst");
`else
        Target = 8'h20;
        instr3("call_ill", 8'h05, 4'h7, 7'h0, 8'h00);
        chk_halt("call_ill/halt", F_HLT | F_FLT);
        do_reset("call_rst");
        instr3("ret_ill", 8'h06, 4'h8, 7'h0, 8'h00);
        chk_halt("ret_ill/halt", F_HLT | F_FLT);
        do_reset("ret_rst");
`endif

        instr3("final_nop", 8'h0C, 4'h0, F_CEN, 8'h0D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
